// File: rtl/imm_const_table.sv
// imm_const_table
//
// Writable immediate-constant table for the fetch/decode stage. An
// instruction address is mapped to a table entry. The entry's stored bits
// are returned expanded to 32 bits according to its format tag (I, J, U or
// RAW). After reset the table clears itself with a sweep, and then accepts
// run-time writes and lookups.
//
// Ports:
//   clk, reset_n          clock; asynchronous active-low reset
//   wr_en/wr_idx/         write one entry per cycle (READY only)
//   wr_type/wr_data
//   lk_valid/lk_ready/    lookup request/accept handshake and address
//   lk_addr
//   rsp_valid/rsp_data/   one-cycle response strobe, expanded immediate,
//   rsp_type/rsp_err      entry tag, and unmapped/misaligned flag
//   err_count             saturating count of erroneous lookups
//   busy                  init sweep in progress
`timescale 1ns/1ps
module imm_const_table #(
    parameter logic [31:0] BASE_ADDR = 32'd40,
    parameter int          DEPTH     = 32,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_type,
    input  logic [31:0]      wr_data,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [31:0]      lk_addr,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic [1:0]       rsp_type,
    output logic             rsp_err,
    output logic [7:0]       err_count,
    output logic             busy
);

    typedef enum logic {INIT, READY} state_t;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] data;
    } entry_t;

    localparam logic [1:0] TYPE_I   = 2'd0;
    localparam logic [1:0] TYPE_J   = 2'd1;
    localparam logic [1:0] TYPE_U   = 2'd2;
    localparam logic [1:0] TYPE_RAW = 2'd3;

    // One extra counter bit: the sweep spends one cycle at cnt == DEPTH after
    // the last entry is written, so READY begins DEPTH+1 edges after reset.
    localparam int CNT_W = IDX_W + 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    entry_t           mem [DEPTH];

    logic             sweep_wr;
    logic             accept;
    logic [31:0]      diff;
    logic [IDX_W-1:0] lk_idx;
    logic             lk_err;
    entry_t           lk_entry;

    function automatic logic [31:0] expand(input logic [1:0] typ, input logic [31:0] v);
        logic [31:0] r;
        unique case (typ)
            TYPE_I:  r = {{20{v[11]}}, v[11:0]};
            TYPE_J:  r = {{11{v[20]}}, v[20:1], 1'b0};
            TYPE_U:  r = {v[19:0], 12'b0};
            default: r = v;
        endcase
        return r;
    endfunction

    // NOTE: sequential state is assigned with <= so every flop samples the
    // values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        lk_ready   = 1'b0;
        unique case (state)
            INIT: begin
                busy = 1'b1;
                if (cnt == CNT_W'(DEPTH)) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                lk_ready = 1'b1;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign sweep_wr = (state == INIT) && !cnt[IDX_W];

    // NOTE: the table array has no reset; the INIT sweep clears it, so the
    // storage can map onto plain RAM/flops without reset wiring.
    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            mem[cnt[IDX_W-1:0]] <= {TYPE_RAW, 32'd0};
        end else if (lk_ready && wr_en) begin
            mem[wr_idx] <= {wr_type, wr_data};
        end
    end

    // Lookup decode. The read is taken combinationally before the edge, so a
    // write to the same entry in the same cycle is not seen (read-before-write).
    assign accept   = lk_valid && lk_ready;
    assign diff     = lk_addr - BASE_ADDR;
    assign lk_idx   = diff[IDX_W+1:2];
    assign lk_err   = (lk_addr < BASE_ADDR) || (lk_addr[1:0] != 2'b00) ||
                      (diff >= 32'(4 * DEPTH));
    assign lk_entry = mem[lk_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_type  <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else begin
            rsp_valid <= accept;
            // Response fields hold their last values between responses.
            if (accept) begin
                rsp_err <= lk_err;
                if (lk_err) begin
                    rsp_data <= '0;
                    rsp_type <= '0;
                end else begin
                    rsp_data <= expand(lk_entry.typ, lk_entry.data);
                    rsp_type <= lk_entry.typ;
                end
                if (lk_err && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_const_table.sv
`timescale 1ns/1ps
module tb_imm_const_table;

    localparam int          DEPTH = 32;
    localparam int          IDX_W = 5;
    localparam logic [31:0] BASE  = 32'd40;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [1:0]       wr_type = '0;
    logic [31:0]      wr_data = '0;
    logic             lk_valid = 1'b0;
    logic [31:0]      lk_addr = '0;
    logic             lk_ready;
    logic             rsp_valid;
    logic [31:0]      rsp_data;
    logic [1:0]       rsp_type;
    logic             rsp_err;
    logic [7:0]       err_count;
    logic             busy;

    imm_const_table #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_type   (wr_type),
        .wr_data   (wr_data),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_addr   (lk_addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_type  (rsp_type),
        .rsp_err   (rsp_err),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]  m_type [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          m_errs;
    logic [31:0] exp_data;
    logic [1:0]  exp_type;
    logic        exp_err;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_type[i] = 2'd3;
            m_data[i] = 32'd0;
        end
        m_errs   = 0;
        exp_data = '0;
        exp_type = '0;
        exp_err  = 1'b0;
    endtask

    // Expansion with plain signed arithmetic on field values.
    function automatic logic [31:0] model_expand(input logic [1:0] t, input logic [31:0] v);
        longint x;
        longint u;
        u = longint'(v);
        case (t)
            2'd0: begin
                x = u % 4096;
                if (x >= 2048) x = x - 4096;
            end
            2'd1: begin
                x = (u / 2) % (64'sd1 << 20);
                if (x >= (64'sd1 << 19)) x = x - (64'sd1 << 20);
                x = x * 2;
            end
            2'd2: x = (u % (64'sd1 << 20)) * 4096;
            default: x = u;
        endcase
        return x[31:0];
    endfunction

    task automatic model_lookup(input logic [31:0] a, output logic [31:0] d,
                                output logic [1:0] t, output logic e);
        longint off;
        int     k;
        off = longint'(a) - longint'(BASE);
        e = (off < 0) || ((a % 4) != 0) || (off >= 4 * DEPTH);
        if (e) begin
            d = '0;
            t = '0;
        end else begin
            k = int'(off / 4);
            t = m_type[k];
            d = model_expand(m_type[k], m_data[k]);
        end
    endtask

    // One clock cycle in READY: drive inputs, advance, check all outputs.
    task automatic cycle(input logic we, input logic [IDX_W-1:0] wi, input logic [1:0] wt,
                         input logic [31:0] wd, input logic lv, input logic [31:0] la,
                         input string tag);
        logic [31:0] ed;
        logic [1:0]  et;
        logic        ee;
        wr_en    = we;
        wr_idx   = wi;
        wr_type  = wt;
        wr_data  = wd;
        lk_valid = lv;
        lk_addr  = la;
        model_lookup(la, ed, et, ee);
        @(posedge clk);
        #1;
        if (we) begin
            m_type[wi] = wt;
            m_data[wi] = wd;
        end
        if (lv) begin
            exp_data = ed;
            exp_type = et;
            exp_err  = ee;
            if (ee && m_errs < 255) m_errs++;
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(lv));
        check({tag, " rsp_data"},  rsp_data,       exp_data);
        check({tag, " rsp_type"},  32'(rsp_type),  32'(exp_type));
        check({tag, " rsp_err"},   32'(rsp_err),   32'(exp_err));
        check({tag, " err_count"}, 32'(err_count), 32'(m_errs));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  typ;
        logic        err;
    } lk_vec_t;

    lk_vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;

        vecs[0] = '{32'd40,  32'hFFFF_FFFF, 2'd0, 1'b0};
        vecs[1] = '{32'd44,  32'hFFFF_FFFE, 2'd1, 1'b0};
        vecs[2] = '{32'd48,  32'h000F_6000, 2'd2, 1'b0};
        vecs[3] = '{32'd52,  32'hDEAD_BEEF, 2'd3, 1'b0};
        vecs[4] = '{32'd36,  32'h0,         2'd0, 1'b1};
        vecs[5] = '{32'd42,  32'h0,         2'd0, 1'b1};
        vecs[6] = '{32'd168, 32'h0,         2'd0, 1'b1};

        model_reset();

        // ---- reset values and init sweep ----
        lk_valid = 1'b1;
        lk_addr  = 32'd40;
        #12;
        check("reset busy",      32'(busy),      32'd1);
        check("reset lk_ready",  32'(lk_ready),  32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data",  rsp_data,       32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check("sweep busy",      32'(busy),      32'd1);
            check("sweep lk_ready",  32'(lk_ready),  32'd0);
            check("sweep rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check("ready lk_ready",  32'(lk_ready),  32'd1);
        check("ready busy",      32'(busy),      32'd0);
        check("ready rsp_valid", 32'(rsp_valid), 32'd0);
        cycle(1'b0, '0, '0, '0, 1'b1, 32'd40, "first");
        check("first data const", rsp_data,      32'd0);
        check("first type const", 32'(rsp_type), 32'd3);

        // ---- format expansion and address errors (table driven) ----
        cycle(1'b1, 5'd0, 2'd0, 32'h0000_0FFF, 1'b0, '0, "wr0");
        cycle(1'b1, 5'd1, 2'd1, 32'h001F_FFFE, 1'b0, '0, "wr1");
        cycle(1'b1, 5'd2, 2'd2, 32'h0000_00F6, 1'b0, '0, "wr2");
        cycle(1'b1, 5'd3, 2'd3, 32'hDEAD_BEEF, 1'b0, '0, "wr3");
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, vecs[i].addr, "vec");
            check("vec data const", rsp_data,       vecs[i].data);
            check("vec type const", 32'(rsp_type),  32'(vecs[i].typ));
            check("vec err const",  32'(rsp_err),   32'(vecs[i].err));
        end
        cycle(1'b0, '0, '0, '0, 1'b0, '0, "idle");
        check("err_count after vectors", 32'(err_count), 32'd3);

        // ---- read-before-write ----
        cycle(1'b1, 5'd5, 2'd0, 32'd8, 1'b0, '0, "rbw setup");
        cycle(1'b1, 5'd5, 2'd0, 32'd25, 1'b1, 32'd60, "rbw same");
        check("rbw old value", rsp_data, 32'd8);
        cycle(1'b0, '0, '0, '0, 1'b1, 32'd60, "rbw next");
        check("rbw new value", rsp_data, 32'd25);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                7:       a = BASE + 4 * $urandom_range(DEPTH, DEPTH + 40);
                8:       a = $urandom_range(0, 39);
                9:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            endcase
            cycle(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, DEPTH - 1)),
                  2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), a, "rand");
        end

        // ---- saturation and streaming ----
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, '0, '0, '0, 1'b1, 32'd0, "sat");
        end
        check("err_count saturated", 32'(err_count), 32'd255);

        // ---- mid-operation reset ----
        cycle(1'b1, 5'd7, 2'd3, 32'h1234_5678, 1'b1, 32'd40, "pre-reset");
        lk_valid = 1'b1;
        lk_addr  = 32'd44;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst err_count", 32'(err_count), 32'd0);
        check("midrst busy",      32'(busy),      32'd1);
        check("midrst lk_ready",  32'(lk_ready),  32'd0);
        check("midrst rsp_data",  rsp_data,       32'd0);
        #1;
        reset_n = 1'b1;
        model_reset();
        n = 0;
        while (!lk_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst sweep length", 32'(n), 32'(DEPTH + 1));
        cycle(1'b0, '0, '0, '0, 1'b1, 32'd40, "after rst e0");
        check("after rst e0 type", 32'(rsp_type), 32'd3);
        cycle(1'b0, '0, '0, '0, 1'b1, 32'd60, "after rst e5");
        check("after rst e5 data", rsp_data, 32'd0);
        cycle(1'b0, '0, '0, '0, 1'b1, 32'd68, "after rst e7");
        check("after rst e7 data", rsp_data, 32'd0);
        cycle(1'b0, '0, '0, '0, 1'b0, '0, "final idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
